// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage of the pipelined MIPS core. Holds
//               the fetch PC, drives the instruction-memory request, and
//               owns the IF/ID pipeline register. It works with a
//               variable-latency instruction memory through a req/ready
//               handshake. While the memory has not responded, it inserts
//               bubbles into IF/ID. When an instruction returns while the
//               pipe is stalled, it parks that instruction in a one-entry
//               buffer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK          in   1   clock, rising edge
//   Reset        in   1   asynchronous active-low reset
//   PCWre        in   1   1 = PC may advance (hazard unit)
//   IFID_Stall   in   1   1 = hold IF/ID contents (hazard unit)
//   PCSrc        in   2   00 seq, 01 branch, 10 jump, 11 jr
//   BranchAddr   in  32   branch target
//   JumpAddr     in  32   jump target
//   JrAddr       in  32   register (jr) target
//   imem_req     out  1   fetch request
//   imem_addr    out 32   fetch address, word aligned
//   imem_rdata   in  32   instruction data, valid with imem_ready
//   imem_ready   in   1   response strobe for the current request
//   PC_IFID      out 32   PC of the instruction in IF/ID
//   PC4_IFID     out 32   PC+4 of the instruction in IF/ID
//   Instr_IFID   out 32   instruction in IF/ID
//   Valid_IFID   out  1   0 = bubble
//   Bubble_Cnt   out 32   cycles IF/ID took a bubble while waiting on imem
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic        IFID_Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchAddr,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] JrAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC_IFID,
    output logic [31:0] PC4_IFID,
    output logic [31:0] Instr_IFID,
    output logic        Valid_IFID,
    output logic [31:0] Bubble_Cnt
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] S_REQ  = 1'b0;   // request outstanding
    localparam logic [0:0] S_HOLD = 1'b1;   // instruction parked in hold_buf

    localparam logic [1:0] c_SRC_SEQ    = 2'b00;
    localparam logic [1:0] c_SRC_BRANCH = 2'b01;
    localparam logic [1:0] c_SRC_JUMP   = 2'b10;

    localparam logic [31:0] c_PC_STEP   = 32'd4;
    localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic        r_drop;        // the outstanding response belongs to a dead path
    logic [31:0] r_redir_pc;    // where to resume once that response is dropped
    logic [31:0] r_hold_buf;
    logic [31:0] r_pc_ifid;
    logic [31:0] r_pc4_ifid;
    logic [31:0] r_instr_ifid;
    logic        r_valid_ifid;
    logic [31:0] r_bubble_cnt;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // A stalled ID instruction has not really been decoded yet, so its
    // PCSrc must not redirect. The stall therefore masks the redirect.
    assign w_stall    = IFID_Stall | ~PCWre;
    assign w_redirect = (PCSrc != c_SRC_SEQ) & ~w_stall;

    always_comb begin
        w_target_raw = JrAddr;
        case (PCSrc)
            c_SRC_BRANCH: w_target_raw = BranchAddr;
            c_SRC_JUMP:   w_target_raw = JumpAddr;
            default:      w_target_raw = JrAddr;
        endcase
    end

    // Targets are forced to a word boundary.
    assign w_target   = {w_target_raw[31:2], 2'b00};
    // 32-bit modulo arithmetic: 0xFFFFFFFC + 4 wraps to 0.
    assign w_pc_plus4 = r_fetch_pc + c_PC_STEP;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // imem_addr comes straight from r_fetch_pc. The address only changes
    // on a response or in S_HOLD, so it stays stable while a request is
    // waiting for ready.
    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_fetch_pc;
    assign PC_IFID    = r_pc_ifid;
    assign PC4_IFID   = r_pc4_ifid;
    assign Instr_IFID = r_instr_ifid;
    assign Valid_IFID = r_valid_ifid;
    assign Bubble_Cnt = r_bubble_cnt;

    // ------------------------------------------------------------------
    // Fetch state machine and IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RESET_PC;
            r_drop       <= 1'b0;
            r_redir_pc   <= RESET_PC;
            r_hold_buf   <= 32'h0;
            r_pc_ifid    <= 32'h0;
            r_pc4_ifid   <= 32'h0;
            r_instr_ifid <= NOP_INSTR;
            r_valid_ifid <= 1'b0;
            r_bubble_cnt <= 32'h0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ready) begin
                        if (r_drop || w_redirect) begin
                            // The returned word is from an abandoned path.
                            // When a fresh redirect arrives together with a
                            // pending drop, the fresh target is newer and wins.
                            r_fetch_pc   <= w_redirect ? w_target : r_redir_pc;
                            r_drop       <= 1'b0;
                            r_instr_ifid <= NOP_INSTR;
                            r_valid_ifid <= 1'b0;
                        end else if (!w_stall) begin
                            r_pc_ifid    <= r_fetch_pc;
                            r_pc4_ifid   <= w_pc_plus4;
                            r_instr_ifid <= imem_rdata;
                            r_valid_ifid <= 1'b1;
                            r_fetch_pc   <= w_pc_plus4;
                        end else begin
                            // Memory delivered but ID cannot accept: park the
                            // word and stop requesting until the stall clears.
                            r_hold_buf   <= imem_rdata;
                            r_state      <= S_HOLD;
                        end
                    end else begin
                        if (w_redirect) begin
                            // The request cannot be withdrawn, so it stays on
                            // the old address. Remember to discard its data.
                            r_drop       <= 1'b1;
                            r_redir_pc   <= w_target;
                            r_instr_ifid <= NOP_INSTR;
                            r_valid_ifid <= 1'b0;
                        end else if (!w_stall) begin
                            r_instr_ifid <= NOP_INSTR;
                            r_valid_ifid <= 1'b0;
                            if (r_bubble_cnt != c_CNT_MAX) begin
                                r_bubble_cnt <= r_bubble_cnt + 32'd1;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (!w_stall) begin
                        if (w_redirect) begin
                            r_fetch_pc   <= w_target;
                            r_instr_ifid <= NOP_INSTR;
                            r_valid_ifid <= 1'b0;
                        end else begin
                            r_pc_ifid    <= r_fetch_pc;
                            r_pc4_ifid   <= w_pc_plus4;
                            r_instr_ifid <= r_hold_buf;
                            r_valid_ifid <= 1'b1;
                            r_fetch_pc   <= w_pc_plus4;
                        end
                        r_state <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. The memory
//               model returns (address | 1) as the instruction word, so every
//               expected instruction can be computed by hand from its PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        CLK;
    logic        Reset;
    logic        PCWre;
    logic        IFID_Stall;
    logic [1:0]  PCSrc;
    logic [31:0] BranchAddr;
    logic [31:0] JumpAddr;
    logic [31:0] JrAddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] PC_IFID;
    logic [31:0] PC4_IFID;
    logic [31:0] Instr_IFID;
    logic        Valid_IFID;
    logic [31:0] Bubble_Cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWre      (PCWre),
        .IFID_Stall (IFID_Stall),
        .PCSrc      (PCSrc),
        .BranchAddr (BranchAddr),
        .JumpAddr   (JumpAddr),
        .JrAddr     (JrAddr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .PC_IFID    (PC_IFID),
        .PC4_IFID   (PC4_IFID),
        .Instr_IFID (Instr_IFID),
        .Valid_IFID (Valid_IFID),
        .Bubble_Cnt (Bubble_Cnt)
    );

    // Memory model: the instruction at address A is A | 1.
    assign imem_rdata = imem_addr | 32'h1;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock cycle: cross a rising edge and settle on the falling edge,
    // where outputs are sampled and new inputs are applied.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        Reset = 1'b0; PCWre = 1'b1; IFID_Stall = 1'b0; PCSrc = 2'b00;
        BranchAddr = 32'h0; JumpAddr = 32'h0; JrAddr = 32'h0; imem_ready = 1'b1;
        step(); step();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        n_checks++; if (Valid_IFID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Valid_IFID); end
        n_checks++; if (Instr_IFID !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", Instr_IFID); end
        n_checks++; if (PC_IFID !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", PC_IFID); end
        n_checks++; if (Bubble_Cnt !== 32'h0) begin n_fail++; $display("FAIL reset_bcnt: got %h expected 0", Bubble_Cnt); end
    endtask

    task automatic test_sequential();
        Reset = 1'b1;
        step();
        n_checks++; if (PC_IFID !== 32'h0) begin n_fail++; $display("FAIL seq0_pc: got %h expected 0", PC_IFID); end
        n_checks++; if (PC4_IFID !== 32'h4) begin n_fail++; $display("FAIL seq0_pc4: got %h expected 4", PC4_IFID); end
        n_checks++; if (Instr_IFID !== 32'h1) begin n_fail++; $display("FAIL seq0_instr: got %h expected 1", Instr_IFID); end
        n_checks++; if (Valid_IFID !== 1'b1) begin n_fail++; $display("FAIL seq0_valid: got %b expected 1", Valid_IFID); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq0_addr: got %h expected 4", imem_addr); end
        step();
        n_checks++; if (PC_IFID !== 32'h4) begin n_fail++; $display("FAIL seq1_pc: got %h expected 4", PC_IFID); end
        n_checks++; if (Instr_IFID !== 32'h5) begin n_fail++; $display("FAIL seq1_instr: got %h expected 5", Instr_IFID); end
        n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq1_addr: got %h expected 8", imem_addr); end
        n_checks++; if (Bubble_Cnt !== 32'h0) begin n_fail++; $display("FAIL seq_bcnt: got %h expected 0", Bubble_Cnt); end
    endtask

    task automatic test_imem_wait();
        imem_ready = 1'b0;
        step();
        n_checks++; if (Valid_IFID !== 1'b0) begin n_fail++; $display("FAIL wait1_valid: got %b expected 0", Valid_IFID); end
        n_checks++; if (Instr_IFID !== 32'h0) begin n_fail++; $display("FAIL wait1_instr: got %h expected 0", Instr_IFID); end
        n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL wait1_addr: got %h expected 8", imem_addr); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait1_req: got %b expected 1", imem_req); end
        n_checks++; if (Bubble_Cnt !== 32'h1) begin n_fail++; $display("FAIL wait1_bcnt: got %h expected 1", Bubble_Cnt); end
        step();
        n_checks++; if (Valid_IFID !== 1'b0) begin n_fail++; $display("FAIL wait2_valid: got %b expected 0", Valid_IFID); end
        n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL wait2_addr: got %h expected 8", imem_addr); end
        n_checks++; if (Bubble_Cnt !== 32'h2) begin n_fail++; $display("FAIL wait2_bcnt: got %h expected 2", Bubble_Cnt); end
        imem_ready = 1'b1;
        step();
        n_checks++; if (PC_IFID !== 32'h8) begin n_fail++; $display("FAIL wait_done_pc: got %h expected 8", PC_IFID); end
        n_checks++; if (Instr_IFID !== 32'h9) begin n_fail++; $display("FAIL wait_done_instr: got %h expected 9", Instr_IFID); end
        n_checks++; if (Valid_IFID !== 1'b1) begin n_fail++; $display("FAIL wait_done_valid: got %b expected 1", Valid_IFID); end
        n_checks++; if (Bubble_Cnt !== 32'h2) begin n_fail++; $display("FAIL wait_done_bcnt: got %h expected 2", Bubble_Cnt); end
    endtask

    // Stall while the word at 0x10 returns. A redirect request and
    // PCWre=0 presented during the stall must both be ignored.
    task automatic test_stall();
        step();   // IF/ID <- 0xC, fetch at 0x10
        IFID_Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                PCWre = 1'b0; PCSrc = 2'b01; BranchAddr = 32'h300;
            end
            step();
            n_checks++; if (PC_IFID !== 32'hC) begin n_fail++; $display("FAIL stall%0d_pc: got %h expected c", i, PC_IFID); end
            n_checks++; if (Instr_IFID !== 32'hD) begin n_fail++; $display("FAIL stall%0d_instr: got %h expected d", i, Instr_IFID); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall%0d_req: got %b expected 0", i, imem_req); end
        end
        IFID_Stall = 1'b0; PCWre = 1'b1; PCSrc = 2'b00;
        step();
        n_checks++; if (PC_IFID !== 32'h10) begin n_fail++; $display("FAIL unstall_pc: got %h expected 10", PC_IFID); end
        n_checks++; if (PC4_IFID !== 32'h14) begin n_fail++; $display("FAIL unstall_pc4: got %h expected 14", PC4_IFID); end
        n_checks++; if (Instr_IFID !== 32'h11) begin n_fail++; $display("FAIL unstall_instr: got %h expected 11", Instr_IFID); end
        n_checks++; if (Valid_IFID !== 1'b1) begin n_fail++; $display("FAIL unstall_valid: got %b expected 1", Valid_IFID); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL unstall_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL unstall_addr: got %h expected 14", imem_addr); end
    endtask

    // Branch with unaligned low bits: the target must be word aligned.
    task automatic test_branch();
        PCSrc = 2'b01; BranchAddr = 32'h103;
        step();
        n_checks++; if (Valid_IFID !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b expected 0", Valid_IFID); end
        n_checks++; if (Instr_IFID !== 32'h0) begin n_fail++; $display("FAIL br_instr: got %h expected 0", Instr_IFID); end
        n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_addr: got %h expected 100", imem_addr); end
        PCSrc = 2'b00;
        step();
        n_checks++; if (PC_IFID !== 32'h100) begin n_fail++; $display("FAIL br_tgt_pc: got %h expected 100", PC_IFID); end
        n_checks++; if (Instr_IFID !== 32'h101) begin n_fail++; $display("FAIL br_tgt_instr: got %h expected 101", Instr_IFID); end
        n_checks++; if (Valid_IFID !== 1'b1) begin n_fail++; $display("FAIL br_tgt_valid: got %b expected 1", Valid_IFID); end
    endtask

    task automatic test_jump_wait();
        PCSrc = 2'b11; JrAddr = 32'h20;
        step();
        n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL jr_addr: got %h expected 20", imem_addr); end
        PCSrc = 2'b10; JumpAddr = 32'h200; imem_ready = 1'b0;
        step();
        n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL jw1_addr: got %h expected 20", imem_addr); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL jw1_req: got %b expected 1", imem_req); end
        n_checks++; if (Valid_IFID !== 1'b0) begin n_fail++; $display("FAIL jw1_valid: got %b expected 0", Valid_IFID); end
        n_checks++; if (Bubble_Cnt !== 32'h2) begin n_fail++; $display("FAIL jw1_bcnt: got %h expected 2", Bubble_Cnt); end
        PCSrc = 2'b00;
        step();
        n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL jw2_addr: got %h expected 20", imem_addr); end
        n_checks++; if (Bubble_Cnt !== 32'h3) begin n_fail++; $display("FAIL jw2_bcnt: got %h expected 3", Bubble_Cnt); end
        imem_ready = 1'b1;
        step();
        n_checks++; if (Valid_IFID !== 1'b0) begin n_fail++; $display("FAIL jw_drop_valid: got %b expected 0", Valid_IFID); end
        n_checks++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL jw_drop_addr: got %h expected 200", imem_addr); end
        step();
        n_checks++; if (PC_IFID !== 32'h200) begin n_fail++; $display("FAIL jw_tgt_pc: got %h expected 200", PC_IFID); end
        n_checks++; if (Instr_IFID !== 32'h201) begin n_fail++; $display("FAIL jw_tgt_instr: got %h expected 201", Instr_IFID); end
        n_checks++; if (Valid_IFID !== 1'b1) begin n_fail++; $display("FAIL jw_tgt_valid: got %b expected 1", Valid_IFID); end
    endtask

    task automatic test_pc_wrap();
        PCSrc = 2'b11; JrAddr = 32'hFFFF_FFFC;
        step();
        PCSrc = 2'b00;
        step();
        n_checks++; if (PC_IFID !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h expected fffffffc", PC_IFID); end
        n_checks++; if (PC4_IFID !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h expected 0", PC4_IFID); end
        n_checks++; if (Instr_IFID !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL wrap_instr: got %h expected fffffffd", Instr_IFID); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 0", imem_addr); end
    endtask

    task automatic test_reset_in_hold();
        IFID_Stall = 1'b1;
        step();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b expected 0", imem_req); end
        #2 Reset = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL hrst_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL hrst_addr: got %h expected 0", imem_addr); end
        n_checks++; if (Valid_IFID !== 1'b0) begin n_fail++; $display("FAIL hrst_valid: got %b expected 0", Valid_IFID); end
        n_checks++; if (PC_IFID !== 32'h0) begin n_fail++; $display("FAIL hrst_pc: got %h expected 0", PC_IFID); end
        n_checks++; if (PC4_IFID !== 32'h0) begin n_fail++; $display("FAIL hrst_pc4: got %h expected 0", PC4_IFID); end
        n_checks++; if (Instr_IFID !== 32'h0) begin n_fail++; $display("FAIL hrst_instr: got %h expected 0", Instr_IFID); end
        n_checks++; if (Bubble_Cnt !== 32'h0) begin n_fail++; $display("FAIL hrst_bcnt: got %h expected 0", Bubble_Cnt); end
        @(negedge CLK);
        IFID_Stall = 1'b0; Reset = 1'b1;
        step();
        n_checks++; if (PC_IFID !== 32'h0) begin n_fail++; $display("FAIL post_rst_pc: got %h expected 0", PC_IFID); end
        n_checks++; if (Instr_IFID !== 32'h1) begin n_fail++; $display("FAIL post_rst_instr: got %h expected 1", Instr_IFID); end
        n_checks++; if (Valid_IFID !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid: got %b expected 1", Valid_IFID); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_imem_wait();
        test_stall();
        test_branch();
        test_jump_wait();
        test_pc_wrap();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
